// File: rtl/loop_tstate_ctrl.sv
// ---------------------------------------------------------------------------
// loop_tstate_ctrl
// Drives the Tstate gating enable of a loop-control gate for a requested
// number of iterations. Each iteration raises Tstate and waits for the gated
// data path (Tstate AND loop data) to come back high. A timer bounds the wait,
// and a fixed low gap separates the iterations. A run ends with a one-cycle
// done pulse and a held status code.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      run request, honoured only while idle
//   iter_cnt   iteration count, captured with start
//   gated_in   returned Tstate-gated data, observed only while Tstate is high
//   abort      terminates a run in progress
//   CELV, CELG, SUB  supply and substrate pins, no logic function
//   Tstate     gating enable to the loop-control gate
//   busy       high while a run is asserting or in a gap
//   done       one-cycle completion pulse
//   status     00 ok, 01 timeout, 10 aborted; held until the next run
//   iter_left  iterations still outstanding
// ---------------------------------------------------------------------------
module loop_tstate_ctrl #(
   parameter int CNT_W   = 8,
   parameter int TO_CYC  = 15,
   parameter int GAP_CYC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] iter_cnt,
   input  logic             gated_in,
   input  logic             abort,
   input  logic             CELV,
   input  logic             CELG,
   input  logic             SUB,
   output logic             Tstate,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status,
   output logic [CNT_W-1:0] iter_left
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ASSERT = 2'b01,
      S_GAP    = 2'b10,
      S_DONE   = 2'b11
   } state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;

   // Last timer value allowed in ASSERT and last gap-counter value in GAP.
   localparam logic [7:0] TO_LIM  = 8'(TO_CYC);
   localparam logic [3:0] GAP_LIM = 4'(GAP_CYC - 1);

   state_e           state_q, state_d;
   logic [7:0]       timer_q, timer_d;
   logic [3:0]       gap_q, gap_d;
   logic [CNT_W-1:0] iter_left_q, iter_left_d;
   logic [1:0]       status_q, status_d;
   logic             tstate_q, tstate_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Supply pins carry no logic; gathered here so they are visibly consumed.
   logic unused_supply_s;
   assign unused_supply_s = CELV ^ CELG ^ SUB;

   // Next-state, counter and output computation.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      gap_d       = gap_q;
      iter_left_d = iter_left_q;
      status_d    = status_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               timer_d     = 8'd0;
               status_d    = ST_OK;
               iter_left_d = iter_cnt;
               if (iter_cnt != {CNT_W{1'b0}}) begin
                  state_d = S_ASSERT;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ASSERT: begin
            // Abort outranks a same-cycle return; a return outranks expiry.
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
            end else if (gated_in) begin
               if (iter_left_q != {CNT_W{1'b0}}) begin
                  iter_left_d = iter_left_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  iter_left_d = iter_left_q;
               end
               if (iter_left_q > {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_d = S_GAP;
                  gap_d   = 4'd0;
               end else begin
                  state_d = S_DONE;
               end
            end else if (timer_q >= TO_LIM) begin
               state_d  = S_DONE;
               status_d = ST_TIMEOUT;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
            end else if (gap_q >= GAP_LIM) begin
               state_d = S_ASSERT;
               timer_d = 8'd0;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register with it.
      tstate_d = (state_d == S_ASSERT);
      busy_d   = (state_d == S_ASSERT) || (state_d == S_GAP);
      done_d   = (state_d == S_DONE);
   end

   // State, counter and registered-output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_q     <= 8'd0;
         gap_q       <= 4'd0;
         iter_left_q <= {CNT_W{1'b0}};
         status_q    <= ST_OK;
         tstate_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         gap_q       <= gap_d;
         iter_left_q <= iter_left_d;
         status_q    <= status_d;
         tstate_q    <= tstate_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign Tstate    = tstate_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign status    = status_q;
   assign iter_left = iter_left_q;

endmodule

// File: tb/tb_loop_tstate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_loop_tstate_ctrl
// Directed bench for loop_tstate_ctrl with default parameters. A behavioural
// model, built from run/iteration bookkeeping, predicts every output each
// cycle; scenario-end literal expectations pin that model down.
// ---------------------------------------------------------------------------
module tb_loop_tstate_ctrl;

   localparam int CNT_W   = 8;
   localparam int TO_CYC  = 15;
   localparam int GAP_CYC = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] iter_cnt = '0;
   logic             gated_in = 1'b0;
   logic             abort = 1'b0;
   logic             Tstate, busy, done;
   logic [1:0]       status;
   logic [CNT_W-1:0] iter_left;

   int checks = 0;
   int errors = 0;

   loop_tstate_ctrl #(.CNT_W(CNT_W), .TO_CYC(TO_CYC), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst(rst), .start(start), .iter_cnt(iter_cnt),
      .gated_in(gated_in), .abort(abort),
      .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
      .Tstate(Tstate), .busy(busy), .done(done),
      .status(status), .iter_left(iter_left)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // run: a run is in progress; age: cycles Tstate has been high this
   // iteration (-1 while low); gap: low cycles still to go.
   int m_run = 0, m_age = -1, m_gap = 0, m_left = 0, m_status = 0, m_done = 0;

   always @(posedge clk or posedge rst) begin : model
      int run, age, gap, left, st, dn;
      if (rst) begin
         m_run <= 0; m_age <= -1; m_gap <= 0; m_left <= 0; m_status <= 0; m_done <= 0;
      end else begin
         run = m_run; age = m_age; gap = m_gap; left = m_left; st = m_status; dn = m_done;
         if (dn != 0) begin
            dn = 0;
         end else if (run == 0) begin
            if (start) begin
               st = 0;
               left = int'(iter_cnt);
               if (left == 0) dn = 1;
               else begin run = 1; age = 0; end
            end
         end else if (abort) begin
            run = 0; age = -1; dn = 1; st = 2;
         end else if (age >= 0) begin
            if (gated_in) begin
               left = left - 1;
               if (left > 0) begin age = -1; gap = GAP_CYC; end
               else begin run = 0; age = -1; dn = 1; end
            end else if (age == TO_CYC) begin
               run = 0; age = -1; dn = 1; st = 1;
            end else begin
               age = age + 1;
            end
         end else begin
            gap = gap - 1;
            if (gap == 0) age = 0;
         end
         m_run <= run; m_age <= age; m_gap <= gap; m_left <= left; m_status <= st; m_done <= dn;
      end
   end

   // ---------------- per-cycle compare ----------------
   int hi_cnt = 0, done_cnt = 0, hi_run = 0;

   always begin : compare
      @(posedge clk);
      #1;
      chk("tstate", int'(Tstate), (m_age >= 0) ? 1 : 0);
      chk("busy", int'(busy), m_run);
      chk("done", int'(done), m_done);
      chk("status", int'(status), m_status);
      chk("iter_left", int'(iter_left), m_left);
      if (Tstate) begin hi_cnt++; hi_run++; end else hi_run = 0;
      if (done) done_cnt++;
      chk("tstate_max_high", (hi_run <= TO_CYC + 1) ? 1 : 0, 1);
   end

   // ---------------- stimulus ----------------
   int h0, d0;

   task automatic go(input int n);
      @(negedge clk);
      start = 1'b1; iter_cnt = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_tstate", int'(Tstate), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_status", int'(status), 0);
      chk("rst_iter_left", int'(iter_left), 0);
      rst = 1'b0;

      // abort while idle does nothing
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_busy", int'(busy), 0);
      chk("idle_abort_done", int'(done), 0);

      // nominal: 3 iterations, return on 2nd ASSERT cycle
      h0 = hi_cnt; d0 = done_cnt;
      go(3);
      chk("nom_tstate_up", int'(Tstate), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); gated_in = 1'b1;
         @(negedge clk); gated_in = 1'b0;
         if (i == 0) chk("nom_left_after1", int'(iter_left), 2);
         if (i == 2) chk("nom_done_pulse", int'(done), 1);
         @(negedge clk);
      end
      chk("nom_hi_cycles", hi_cnt - h0, 6);
      chk("nom_done_cnt", done_cnt - d0, 1);
      chk("nom_status", int'(status), 0);
      chk("nom_iter_left", int'(iter_left), 0);

      // zero count
      h0 = hi_cnt; d0 = done_cnt;
      go(0);
      chk("zero_done", int'(done), 1);
      @(negedge clk);
      chk("zero_hi_cycles", hi_cnt - h0, 0);
      chk("zero_done_cnt", done_cnt - d0, 1);
      chk("zero_status", int'(status), 0);

      // timeout with start ignored while busy
      h0 = hi_cnt; d0 = done_cnt;
      go(2);
      start = 1'b1; iter_cnt = CNT_W'(5);
      repeat (16) @(negedge clk);
      chk("to_done", int'(done), 1);
      @(negedge clk);
      start = 1'b0;
      chk("to_hi_cycles", hi_cnt - h0, 16);
      chk("to_status", int'(status), 1);
      chk("to_iter_left", int'(iter_left), 2);
      chk("to_done_cnt", done_cnt - d0, 1);
      chk("to_idle_busy", int'(busy), 0);

      // collision: abort and return together
      go(1);
      gated_in = 1'b1; abort = 1'b1;
      @(negedge clk);
      gated_in = 1'b0; abort = 1'b0;
      chk("col_tstate", int'(Tstate), 0);
      chk("col_status", int'(status), 2);
      chk("col_iter_left", int'(iter_left), 1);
      @(negedge clk);

      // boundary: return exactly on expiry, pulse during GAP ignored
      h0 = hi_cnt;
      go(2);
      repeat (15) @(negedge clk);
      gated_in = 1'b1;
      @(negedge clk);
      chk("bnd_gap_tstate", int'(Tstate), 0);
      chk("bnd_left", int'(iter_left), 1);
      chk("bnd_busy", int'(busy), 1);
      @(negedge clk);
      gated_in = 1'b0;
      chk("bnd_gap_ignored", int'(iter_left), 1);
      chk("bnd_reassert", int'(Tstate), 1);
      gated_in = 1'b1;
      @(negedge clk);
      gated_in = 1'b0;
      chk("bnd_status", int'(status), 0);
      chk("bnd_left_final", int'(iter_left), 0);
      chk("bnd_hi_cycles", hi_cnt - h0, 17);
      @(negedge clk);

      // abort in GAP
      go(3);
      gated_in = 1'b1;
      @(negedge clk);
      gated_in = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("gap_abort_status", int'(status), 2);
      chk("gap_abort_left", int'(iter_left), 2);
      @(negedge clk);

      // reset mid-run during iteration 2 of 4
      d0 = done_cnt;
      go(4);
      gated_in = 1'b1;
      @(negedge clk);
      gated_in = 1'b0;
      @(negedge clk);
      chk("rr_iter2_tstate", int'(Tstate), 1);
      rst = 1'b1;
      #1;
      chk("rr_async_tstate", int'(Tstate), 0);
      chk("rr_async_busy", int'(busy), 0);
      chk("rr_async_left", int'(iter_left), 0);
      chk("rr_async_status", int'(status), 0);
      repeat (2) @(negedge clk);
      chk("rr_no_done", done_cnt - d0, 0);
      rst = 1'b0;
      start = 1'b1; iter_cnt = CNT_W'(1);
      @(negedge clk);
      start = 1'b0;
      chk("rr_first_start", int'(Tstate), 1);
      gated_in = 1'b1;
      @(negedge clk);
      gated_in = 1'b0;
      chk("rr_done", int'(done), 1);
      chk("rr_status", int'(status), 0);
      chk("rr_left", int'(iter_left), 0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/loop_tstate_ctrl.md
LOOP_TSTATE_CTRL -- requirements
Module: loop_tstate_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the iteration counter.
REQ-002 Parameter TO_CYC, default 15: maximum cycles Tstate stays high waiting for a return, range 1..255.
REQ-003 Parameter GAP_CYC, default 1: cycles Tstate stays low between iterations, range 1..15.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a loop run; sampled only in IDLE.
REQ-007 iter_cnt  input  CNT_W  number of iterations, captured with start.
REQ-008 gated_in  input  1  returned Tstate-gated data path, i.e. the AND of Tstate and loop data.
REQ-009 abort  input  1  terminate the run in progress.
REQ-010 Tstate  output  1  gating enable driven to the loop-control gate.
REQ-011 busy  output  1  high in ASSERT and GAP.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 status  output  2  run result: 00 ok, 01 timeout, 10 aborted; held until the next accepted start.
REQ-014 iter_left  output  CNT_W  iterations remaining.
REQ-015 CELV, CELG, SUB  input  1 each  supply and substrate pins; no functional effect.

Function
REQ-016 The FSM shall have the states IDLE, ASSERT, GAP and DONE; all outputs shall be registered.
REQ-017 IDLE, start=1, iter_cnt!=0: next state ASSERT; iter_left<=iter_cnt; status<=00; Tstate rises one cycle after start.
REQ-018 IDLE, start=1, iter_cnt==0: next state DONE; status<=00; Tstate shall not assert.
REQ-019 start outside IDLE shall be ignored, including the DONE cycle.
REQ-020 ASSERT: Tstate=1; a wait timer shall count up from 0 on each entry.
REQ-021 gated_in shall be sampled only in ASSERT and ignored in all other states.
REQ-022 ASSERT, gated_in=1: iter_left decrements by 1 next cycle; Tstate=0 next cycle; next state GAP if iter_left>1, else DONE.
REQ-023 GAP: Tstate=0 for exactly GAP_CYC cycles, then return to ASSERT.
REQ-024 ASSERT, timer reaches TO_CYC with gated_in=0: next state DONE; status<=01; iter_left holds.
REQ-025 gated_in=1 in the same cycle the timer expires shall count as a success, with no timeout.
REQ-026 abort=1 in ASSERT or GAP: next state DONE; status<=10; Tstate=0 next cycle; iter_left holds.
REQ-027 abort=1 in the same cycle as gated_in=1 shall win, and that iteration shall not be counted.
REQ-028 abort in IDLE or DONE shall have no effect.
REQ-029 DONE shall last one cycle: done=1, busy=0, Tstate=0; next state IDLE.
REQ-030 iter_left shall never wrap below 0; the decrement shall occur only in ASSERT with gated_in=1.
REQ-031 Tstate shall never be high for more than TO_CYC+1 consecutive cycles.

Reset
REQ-032 rst=1 shall force state IDLE, Tstate=0, busy=0, done=0, status=00, iter_left=0 and timer=0, asynchronously.
REQ-033 rst asserted mid-run shall drop Tstate immediately, produce no done pulse, and resume in IDLE after deassertion.
REQ-034 The first start shall be honored on the first rising edge after rst deasserts.

Verification
REQ-035 Nominal: start with iter_cnt=3, gated_in=1 on the second ASSERT cycle of each iteration (GAP_CYC=1) -> Tstate high 2 cycles x3, low 1 cycle between, done once, status=00, iter_left 3->2->1->0.
REQ-036 Zero count: start with iter_cnt=0 -> done one cycle later, Tstate never high, status=00.
REQ-037 Timeout: start with iter_cnt=2, gated_in held 0 -> Tstate high TO_CYC+1=16 cycles, done, status=01, iter_left=2.
REQ-038 Collision: gated_in=1 and abort=1 in the same ASSERT cycle with iter_cnt=1 -> status=10, iter_left=1, Tstate low next cycle.
REQ-039 Boundary: gated_in=1 exactly on the timer-expiry cycle -> no timeout, iteration counted; gated_in pulses during GAP -> ignored.
REQ-040 Reset mid-run: rst pulsed during ASSERT of iteration 2 of 4 -> Tstate=0 immediately, no done, outputs at reset values; a new start with iter_cnt=1 completes normally.
